fusion_frame_sequencer: RTL and testbench

Frame-level controller in front of the fusion core. It joins four 8-bit pixel streams (avg, new, fused, old) into the packed 32-bit word the core consumes: {old, fused, new, avg} in bits [31:24]/[23:16]/[15:8]/[7:0]. It counts pixels and frames, asserts tlast on the final pixel of each frame, and forces old=0 during window warm-up, i.e. the first NO_IMAGES frames after reset.

---
 rtl/fusion_frame_sequencer_pkg.sv | 25 ++
 rtl/fusion_join_slot.sv | 71 +++++++
 rtl/fusion_frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_fusion_frame_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_frame_sequencer_pkg.sv
// Shared definitions for the fusion frame sequencer: FSM encoding, byte-lane
// positions inside the packed core word, and the frame size helper.
package fusion_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Lane index within the packed word {old, fused, new, avg}.
    localparam int LANE_AVG   = 0;
    localparam int LANE_NEW   = 1;
    localparam int LANE_FUSED = 2;
    localparam int LANE_OLD   = 3;

    localparam int DEF_IM_LEN       = 520;
    localparam int DEF_IM_WID       = 520;
    localparam int PIXELS_PER_FRAME = DEF_IM_LEN * DEF_IM_WID;

    function automatic int pixels_per_frame(input int im_len, input int im_wid);
        return im_len * im_wid;
    endfunction

endpackage

// File: rtl/fusion_join_slot.sv
// Four-input stream join feeding a one-deep registered output slot.
// Every participating source is consumed in the same cycle or not at all.
module fusion_join_slot
    import fusion_frame_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int OUTPUT_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         warmup,
    input  logic                         flush,
    input  logic                         last_in,
    input  logic                         avg_valid,
    input  logic [DATA_WIDTH-1:0]        avg_data,
    input  logic                         new_valid,
    input  logic [DATA_WIDTH-1:0]        new_data,
    input  logic                         fused_valid,
    input  logic [DATA_WIDTH-1:0]        fused_data,
    input  logic                         old_valid,
    input  logic [DATA_WIDTH-1:0]        old_data,
    output logic                         avg_ready,
    output logic                         new_ready,
    output logic                         fused_ready,
    output logic                         old_ready,
    output logic                         join_ok,
    output logic                         out_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    input  logic                         out_ready
);

    logic                         slot_free;
    logic [OUTPUT_DATA_WIDTH-1:0] packed_word;

    // Slot frees up in the same cycle its current word is taken, giving 1 word/cycle.
    assign slot_free = !out_valid || out_ready;
    assign join_ok   = enable && avg_valid && new_valid && fused_valid
                     && (old_valid || warmup) && slot_free;

    assign avg_ready   = join_ok;
    assign new_ready   = join_ok;
    assign fused_ready = join_ok;
    assign old_ready   = join_ok && !warmup;

    always_comb begin
        packed_word = '0;
        packed_word[LANE_AVG*DATA_WIDTH   +: DATA_WIDTH] = avg_data;
        packed_word[LANE_NEW*DATA_WIDTH   +: DATA_WIDTH] = new_data;
        packed_word[LANE_FUSED*DATA_WIDTH +: DATA_WIDTH] = fused_data;
        packed_word[LANE_OLD*DATA_WIDTH   +: DATA_WIDTH] = warmup ? '0 : old_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (join_ok) begin
            out_valid <= 1'b1;
            out_data  <= packed_word;
            out_last  <= last_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fusion_frame_sequencer.sv
// Frame controller in front of the fusion core: pixel/frame counting, tlast,
// and warm-up gating of the old stream. Optional stall watchdog: FUSION_SEQ_TIMEOUT_EN.
module fusion_frame_sequencer
    import fusion_frame_sequencer_pkg::*;
#(
    parameter int IM_LEN            = DEF_IM_LEN,
    parameter int IM_WID            = DEF_IM_WID,
    parameter int NO_IMAGES         = 16,
    parameter int LOG2_NO_OF_IMAGES = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int FRAME_IDX_WIDTH   = 16
`ifdef FUSION_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES    = 1024
`endif
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset_n,
    input  logic                         start,
    input  logic                         s_avg_valid,
    output logic                         s_avg_ready,
    input  logic [DATA_WIDTH-1:0]        s_avg_data,
    input  logic                         s_new_valid,
    output logic                         s_new_ready,
    input  logic [DATA_WIDTH-1:0]        s_new_data,
    input  logic                         s_fused_valid,
    output logic                         s_fused_ready,
    input  logic [DATA_WIDTH-1:0]        s_fused_data,
    input  logic                         s_old_valid,
    output logic                         s_old_ready,
    input  logic [DATA_WIDTH-1:0]        s_old_data,
    output logic                         m_axis_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0] m_axis_output,
    input  logic                         m_axis_ready,
    output logic                         m_axis_last,
`ifdef FUSION_SEQ_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output logic                         busy,
    output logic                         frame_done,
    output logic                         warmup,
    output logic [FRAME_IDX_WIDTH-1:0]   frame_index
);

    localparam int NPIX = pixels_per_frame(IM_LEN, IM_WID);
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int FS_W = LOG2_NO_OF_IMAGES + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [FS_W-1:0] WARM_FRAMES = FS_W'(NO_IMAGES);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] pixel_cnt;
    logic [FS_W-1:0]  frames_seen;
    logic             all_joined;
    logic             join_en, join_ok, out_hs, last_pix, abort;

    assign join_en  = (state == ST_RUN) && !all_joined;
    assign out_hs   = m_axis_valid && m_axis_ready;
    assign last_pix = (pixel_cnt == LAST_PIX);
    // frames_seen only moves in DONE, so warmup is constant across a frame.
    assign warmup     = (frames_seen < WARM_FRAMES);
    assign busy       = (state == ST_RUN);
    assign frame_done = (state == ST_DONE);

`ifdef FUSION_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] stall_cnt;

    assign abort       = (state == ST_RUN) && !join_ok && !out_hs && (stall_cnt == TO_LAST);
    assign timeout_err = abort;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            stall_cnt <= '0;
        end else if ((state != ST_RUN) || join_ok || out_hs || abort) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + TO_W'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    fusion_join_slot #(
        .DATA_WIDTH        (DATA_WIDTH),
        .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
    ) u_join_slot (
        .clk         (axi_clk),
        .rst_n       (axi_reset_n),
        .enable      (join_en),
        .warmup      (warmup),
        .flush       (abort),
        .last_in     (last_pix),
        .avg_valid   (s_avg_valid),
        .avg_data    (s_avg_data),
        .new_valid   (s_new_valid),
        .new_data    (s_new_data),
        .fused_valid (s_fused_valid),
        .fused_data  (s_fused_data),
        .old_valid   (s_old_valid),
        .old_data    (s_old_data),
        .avg_ready   (s_avg_ready),
        .new_ready   (s_new_ready),
        .fused_ready (s_fused_ready),
        .old_ready   (s_old_ready),
        .join_ok     (join_ok),
        .out_valid   (m_axis_valid),
        .out_data    (m_axis_output),
        .out_last    (m_axis_last),
        .out_ready   (m_axis_ready)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort) state_nxt = ST_IDLE;
                else if (out_hs && m_axis_last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state       <= ST_IDLE;
            pixel_cnt   <= '0;
            all_joined  <= 1'b0;
            frames_seen <= '0;
            frame_index <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_RUN: begin
                    if (join_ok) begin
                        pixel_cnt <= pixel_cnt + CNT_W'(1);
                        if (last_pix) all_joined <= 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_index <= frame_index + FRAME_IDX_WIDTH'(1);
                    if (frames_seen < WARM_FRAMES) frames_seen <= frames_seen + FS_W'(1);
                end
                default: begin
                    pixel_cnt  <= '0;
                    all_joined <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fusion_frame_sequencer.sv
// Directed bench for fusion_frame_sequencer with a 4x4 frame and a 2-frame warm-up window.
module tb_fusion_frame_sequencer;

    localparam int NPIX = 16;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        start;
    logic        s_avg_valid, s_avg_ready;
    logic [7:0]  s_avg_data;
    logic        s_new_valid, s_new_ready;
    logic [7:0]  s_new_data;
    logic        s_fused_valid, s_fused_ready;
    logic [7:0]  s_fused_data;
    logic        s_old_valid, s_old_ready;
    logic [7:0]  s_old_data;
    logic        m_axis_valid, m_axis_ready, m_axis_last;
    logic [31:0] m_axis_output;
    logic        busy, frame_done, warmup;
    logic [15:0] frame_index;
`ifdef FUSION_SEQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 axi_clk = ~axi_clk;

    fusion_frame_sequencer #(
        .IM_LEN            (4),
        .IM_WID            (4),
        .NO_IMAGES         (2),
        .LOG2_NO_OF_IMAGES (1),
        .DATA_WIDTH        (8),
        .OUTPUT_DATA_WIDTH (32),
        .FRAME_IDX_WIDTH   (16)
`ifdef FUSION_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES    (8)
`endif
    ) dut (
        .axi_clk       (axi_clk),
        .axi_reset_n   (axi_reset_n),
        .start         (start),
        .s_avg_valid   (s_avg_valid),
        .s_avg_ready   (s_avg_ready),
        .s_avg_data    (s_avg_data),
        .s_new_valid   (s_new_valid),
        .s_new_ready   (s_new_ready),
        .s_new_data    (s_new_data),
        .s_fused_valid (s_fused_valid),
        .s_fused_ready (s_fused_ready),
        .s_fused_data  (s_fused_data),
        .s_old_valid   (s_old_valid),
        .s_old_ready   (s_old_ready),
        .s_old_data    (s_old_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_output (m_axis_output),
        .m_axis_ready  (m_axis_ready),
        .m_axis_last   (m_axis_last),
`ifdef FUSION_SEQ_TIMEOUT_EN
        .timeout_err   (timeout_err),
`endif
        .busy          (busy),
        .frame_done    (frame_done),
        .warmup        (warmup),
        .frame_index   (frame_index)
    );

    logic [32:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_no = 0;
    int          ptr_avg, ptr_new, ptr_fused, ptr_old;
    int          done_seen, pops;
    logic        exp_warm = 1'b1;
    logic        new_gap = 1'b0;
    logic        out_stall = 1'b0;
    logic        held_valid = 1'b0;
    logic [32:0] held_word = '0;
    logic        done_pending = 1'b0;

    function automatic logic [7:0] px(input int frame, input int lane, input int idx);
        if (lane == 3) return 8'hA5 ^ 8'(idx + frame * 16);
        return 8'(frame * 16 + lane * 64 + idx);
    endfunction

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 2ns later (before posedge), then advance.
    task automatic tick(input logic st);
        logic [32:0] got;
        @(negedge axi_clk);
        start         = st;
        s_avg_valid   = 1'b1;
        s_avg_data    = px(frame_no, 0, ptr_avg);
        s_new_valid   = !new_gap;
        s_new_data    = px(frame_no, 1, ptr_new);
        s_fused_valid = 1'b1;
        s_fused_data  = px(frame_no, 2, ptr_fused);
        s_old_valid   = 1'b1;
        s_old_data    = px(frame_no, 3, ptr_old);
        m_axis_ready  = !out_stall;
        #2;
        got = {m_axis_last, m_axis_output};
        check(64'(s_new_ready), 64'(s_avg_ready), "new_ready_join");
        check(64'(s_fused_ready), 64'(s_avg_ready), "fused_ready_join");
        check(64'(s_old_ready), 64'(s_avg_ready & !exp_warm), "old_ready_join");
        if (!s_new_valid || (m_axis_valid && !m_axis_ready))
            check(64'(s_avg_ready), 64'(0), "ready_blocked");
        if (busy) check(64'(warmup), 64'(exp_warm), "warmup_flag");
        check(64'(frame_done & busy), 64'(0), "done_with_busy");
        if (held_valid) begin
            check(64'(m_axis_valid), 64'(1), "hold_valid");
            check(64'(got), 64'(held_word), "hold_stable");
        end
        held_valid = m_axis_valid && !m_axis_ready;
        held_word  = got;
        if (done_pending) check(64'(frame_done), 64'(1), "frame_done_timing");
        done_pending = 1'b0;
        if (frame_done) done_seen++;
        if (m_axis_valid && m_axis_ready) begin
            pops++;
            check(64'(exp_q.size() > 0), 64'(1), "word_expected");
            if (exp_q.size() > 0) check(64'(got), 64'(exp_q.pop_front()), "word_data");
            if (m_axis_last) done_pending = 1'b1;
        end
        if (s_avg_ready) ptr_avg++;
        if (s_new_ready) ptr_new++;
        if (s_fused_ready) ptr_fused++;
        if (s_old_ready) ptr_old++;
        @(posedge axi_clk);
    endtask

    task automatic run_frame(input logic warm, input int gap_at, input int stall_at,
                             input int abort_after);
        frame_no++;
        exp_warm  = warm;
        ptr_avg   = 0;
        ptr_new   = 0;
        ptr_fused = 0;
        ptr_old   = 0;
        done_seen = 0;
        pops      = 0;
        for (int i = 0; i < NPIX; i++)
            exp_q.push_back({(i == NPIX - 1), (warm ? 8'h00 : px(frame_no, 3, i)),
                             px(frame_no, 2, i), px(frame_no, 1, i), px(frame_no, 0, i)});
        tick(1'b1);
        for (int t = 0; t < 100; t++) begin
            new_gap   = (t >= gap_at) && (t < gap_at + 5);
            out_stall = (t >= stall_at) && (t < stall_at + 3);
            if (abort_after > 0 && pops >= abort_after) break;
            tick(1'b0);
            if (done_seen > 0) break;
        end
        new_gap   = 1'b0;
        out_stall = 1'b0;
        if (abort_after == 0) begin
            check(64'(done_seen), 64'(1), "frame_done_seen");
            check(64'(exp_q.size()), 64'(0), "all_words_out");
        end
    endtask

    initial begin
        axi_reset_n   = 1'b0;
        start         = 1'b0;
        s_avg_valid   = 1'b0;
        s_new_valid   = 1'b0;
        s_fused_valid = 1'b0;
        s_old_valid   = 1'b0;
        s_avg_data    = '0;
        s_new_data    = '0;
        s_fused_data  = '0;
        s_old_data    = '0;
        m_axis_ready  = 1'b1;
        ptr_avg = 0; ptr_new = 0; ptr_fused = 0; ptr_old = 0;
        done_seen = 0; pops = 0;
        repeat (2) @(negedge axi_clk);
        #2;
        check(64'(m_axis_valid), 64'(0), "rst_valid");
        check(64'(m_axis_output), 64'(0), "rst_output");
        check(64'(m_axis_last), 64'(0), "rst_last");
        check(64'(busy), 64'(0), "rst_busy");
        check(64'(frame_done), 64'(0), "rst_frame_done");
        check(64'(warmup), 64'(1), "rst_warmup");
        check(64'(frame_index), 64'(0), "rst_frame_index");
        @(negedge axi_clk);
        axi_reset_n = 1'b1;

        // Warm-up frame with a 5-cycle gap on the new stream.
        run_frame(1'b1, 5, 1000, 0);
        tick(1'b0);
        check(64'(frame_index), 64'(1), "frame_index_1");

        // Warm-up frame with 3 cycles of core back-pressure.
        run_frame(1'b1, 1000, 6, 0);
        tick(1'b0);
        check(64'(frame_index), 64'(2), "frame_index_2");
        check(64'(warmup), 64'(0), "warmup_cleared");

        // Steady-state frame: old stream now participates.
        run_frame(1'b0, 1000, 1000, 0);
        tick(1'b0);
        check(64'(frame_index), 64'(3), "frame_index_3");

        // Abort mid-frame with reset after 7 words.
        run_frame(1'b0, 1000, 1000, 7);
        #1 axi_reset_n = 1'b0;
        #1;
        check(64'(m_axis_valid), 64'(0), "abort_valid");
        check(64'(m_axis_output), 64'(0), "abort_output");
        check(64'(busy), 64'(0), "abort_busy");
        check(64'(warmup), 64'(1), "abort_warmup");
        check(64'(frame_index), 64'(0), "abort_frame_index");
        exp_q.delete();
        held_valid   = 1'b0;
        done_pending = 1'b0;
        @(negedge axi_clk);
        axi_reset_n = 1'b1;

        // Full frame after reset restarts warm-up.
        run_frame(1'b1, 1000, 1000, 0);
        tick(1'b0);
        check(64'(frame_index), 64'(1), "frame_index_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
